// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment bus: segment patterns, digit
// select encodings, and the decoder FSM state type.
package seg_pkg;

   // Segment patterns with bit0=a .. bit6=g (decimal point excluded)
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [2:0] BLANK_CODE = 3'd7;

   // One-hot digit selects; bit4 is never driven by a healthy controller
   localparam logic [4:0] SEL_IDLE = 5'b00000;
   localparam logic [4:0] SEL_POS0 = 5'b01000;
   localparam logic [4:0] SEL_POS1 = 5'b00100;
   localparam logic [4:0] SEL_POS2 = 5'b00010;
   localparam logic [4:0] SEL_POS3 = 5'b00001;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HELD
   } state_t;

   typedef struct packed {
      logic       legal;
      logic [1:0] idx;
   } sel_dec_t;

   // Map a select value to a digit position; anything but the four
   // one-hot positions is illegal
   function automatic sel_dec_t decode_sel(input logic [4:0] sel);
      sel_dec_t d;
      d.legal = 1'b1;
      d.idx   = 2'd0;
      case (sel)
         SEL_POS0: d.idx = 2'd0;
         SEL_POS1: d.idx = 2'd1;
         SEL_POS2: d.idx = 2'd2;
         SEL_POS3: d.idx = 2'd3;
         default:  d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to digit-code lookup. Blank decodes to
// BLANK_CODE; any pattern outside the table is flagged as not legal.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [2:0] o_code,
   output logic       o_legal
);

   // Table lookup of the seven segment lines
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      o_code  = 3'd0;
      o_legal = 1'b1;
      case (i_seg)
         SEG_0:     o_code = 3'd0;
         SEG_1:     o_code = 3'd1;
         SEG_2:     o_code = 3'd2;
         SEG_3:     o_code = 3'd3;
         SEG_4:     o_code = 3'd4;
         SEG_5:     o_code = 3'd5;
         SEG_BLANK: o_code = BLANK_CODE;
         default:   o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_bus_decoder.sv
// Receiver for the multiplexed seven-segment bus. Each digit must hold
// steady for STABLE_CYCLES registered samples before it is committed; four
// committed positions form a frame on digits_out. Sticky error flags and a
// link-lost timeout support readback checking of the parking display.
// Optional build macro SEG_DECODER_DP_CAPTURE_EN adds per-position decimal
// point capture on dp_out.
module seg_bus_decoder
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 8192
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seg_in,
   input  logic [4:0]  sel_in,
   input  logic        err_clr,
   output logic [11:0] digits_out,
   output logic        frame_valid,
   output logic        err_pattern,
   output logic        err_select,
   output logic        link_lost
`ifdef SEG_DECODER_DP_CAPTURE_EN
   ,
   output logic [3:0]  dp_out
`endif
);

   localparam int STW = $clog2(STABLE_CYCLES + 1);
   localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SEG_DECODER_DP_CAPTURE_EN
   localparam int CW = 8;
`else
   localparam int CW = 7;
   logic w_unused_dp;
   assign w_unused_dp = seg_in[7];
`endif

   logic [CW-1:0]   r_seg, r_prev_seg;
   logic [4:0]      r_sel, r_prev_sel;
   state_t          r_state, w_state_nxt;
   logic [STW-1:0]  r_stable, w_stable_nxt;
   logic [TOW-1:0]  r_tmo;
   logic [3:0][2:0] r_slot, w_slot_nxt;
   logic [3:0]      r_mask, w_mask_nxt;
   logic [11:0]     r_digits;
   logic            r_frame_valid, r_err_pattern, r_err_select;
   logic            w_same, w_sel_nz, w_commit, w_wr, w_frame_done;
   logic            w_err_pat_set, w_err_sel_set;
   logic [2:0]      w_code;
   logic            w_legal;
   sel_dec_t        w_pos;

   // Input sampling stage plus the previous sample for stability compare
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         r_seg      <= '0;
         r_sel      <= '0;
         r_prev_seg <= '0;
         r_prev_sel <= '0;
      end else begin
         r_seg      <= seg_in[CW-1:0];
         r_sel      <= sel_in;
         r_prev_seg <= r_seg;
         r_prev_sel <= r_sel;
      end
   end

   assign w_same   = (r_seg == r_prev_seg) && (r_sel == r_prev_sel);
   assign w_sel_nz = (r_sel != SEL_IDLE);
   assign w_pos    = decode_sel(r_sel);

   seg_pattern_decode u_decode (
      .i_seg   (r_seg[6:0]),
      .o_code  (w_code),
      .o_legal (w_legal)
   );

   // FSM state and stability counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_stable <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_stable <= w_stable_nxt;
      end
   end

   // Next state: any change restarts the count, idle select drops to IDLE
   always_comb begin
      w_state_nxt  = r_state;
      w_stable_nxt = r_stable;
      if (!w_sel_nz) begin
         w_state_nxt  = ST_IDLE;
         w_stable_nxt = '0;
      end else if (r_state == ST_IDLE || !w_same) begin
         w_stable_nxt = STW'(1);
         w_state_nxt  = (STABLE_CYCLES <= 1) ? ST_HELD : ST_SETTLE;
      end else if (r_state == ST_SETTLE) begin
         if (r_stable < STW'(STABLE_CYCLES))
            w_stable_nxt = r_stable + STW'(1);
         if (r_stable + STW'(1) >= STW'(STABLE_CYCLES))
            w_state_nxt = ST_HELD;
      end
   end

   // Commit strobe: entering HELD, but never while a held sample is unchanged
   always_comb begin
      w_commit = (w_state_nxt == ST_HELD) && !((r_state == ST_HELD) && w_same);
   end

   assign w_wr          = w_commit && w_pos.legal && w_legal;
   assign w_err_pat_set = w_commit && w_pos.legal && !w_legal;
   assign w_err_sel_set = w_commit && !w_pos.legal;
   assign w_mask_nxt    = r_mask | (w_wr ? (4'b0001 << w_pos.idx) : 4'b0000);
   assign w_frame_done  = w_wr && (w_mask_nxt == 4'hF);

   // Shadow slots including the code being committed this cycle
   always_comb begin
      w_slot_nxt = r_slot;
      if (w_wr)
         w_slot_nxt[w_pos.idx] = w_code;
   end

   // Shadow slots, capture mask and frame output
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the four shadow slots are reset so a partial frame can never leak stale digits after reset.
      if (!rst_n) begin
         r_slot        <= '0;
         r_mask        <= '0;
         r_digits      <= '0;
         r_frame_valid <= 1'b0;
      end else begin
         r_slot        <= w_slot_nxt;
         r_mask        <= w_frame_done ? 4'h0 : w_mask_nxt;
         r_frame_valid <= w_frame_done;
         if (w_frame_done)
            r_digits <= {w_slot_nxt[0], w_slot_nxt[1], w_slot_nxt[2], w_slot_nxt[3]};
      end
   end

   // Sticky error flags; a new error in the clear cycle wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_pattern <= 1'b0;
         r_err_select  <= 1'b0;
      end else begin
         r_err_pattern <= w_err_pat_set | (r_err_pattern & ~err_clr);
         r_err_select  <= w_err_sel_set | (r_err_select & ~err_clr);
      end
   end

   // Frame timeout counter, cleared by each completed frame, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_tmo <= '0;
      else if (w_frame_done)
         r_tmo <= '0;
      else if (r_tmo != TOW'(TIMEOUT_CYCLES))
         r_tmo <= r_tmo + TOW'(1);
   end

`ifdef SEG_DECODER_DP_CAPTURE_EN
   logic [3:0] r_dp_slot, r_dp_out, w_dp_nxt;

   // Decimal point shadow, merged the same way as the digit slots
   always_comb begin
      w_dp_nxt = r_dp_slot;
      if (w_wr)
         w_dp_nxt[w_pos.idx] = r_seg[7];
   end

   // Decimal point shadow and output, transferred with digits_out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dp_slot <= '0;
         r_dp_out  <= '0;
      end else begin
         r_dp_slot <= w_dp_nxt;
         if (w_frame_done)
            r_dp_out <= {w_dp_nxt[0], w_dp_nxt[1], w_dp_nxt[2], w_dp_nxt[3]};
      end
   end

   assign dp_out = r_dp_out;
`endif

   assign digits_out  = r_digits;
   assign frame_valid = r_frame_valid;
   assign err_pattern = r_err_pattern;
   assign err_select  = r_err_select;
   assign link_lost   = (r_tmo == TOW'(TIMEOUT_CYCLES));

endmodule
